// File: rtl/rx_mem_pkg.sv
// Shared types, defaults and slot/address helpers
// for the receive packet-buffer allocator.
package rx_mem_pkg;

  localparam int DEF_NUM_SLOTS  = 1024;
  localparam int DEF_SLOT_BYTES = 2048;
  localparam int MAX_AW         = 64;

  typedef logic [$clog2(DEF_NUM_SLOTS)-1:0] slot_idx_t;
  typedef logic [MAX_AW-1:0] wide_addr_t;

  localparam int ERR_ACK_UNDERFLOW = 0;
  localparam int ERR_BAD_FREE      = 1;
  localparam int ERR_LEN_OVERFLOW  = 2;

  function automatic wide_addr_t idx_to_addr(
    input wide_addr_t idx,
    input wide_addr_t base,
    input int         sb_log2
  );
    return base + (idx << sb_log2);
  endfunction

  function automatic wide_addr_t addr_to_idx(
    input wide_addr_t addr,
    input wide_addr_t base,
    input int         sb_log2
  );
    return (addr - base) >> sb_log2;
  endfunction

endpackage

// File: rtl/rx_buffer_allocator_ram.sv
// Simple dual-port free-list RAM, one write
// port and one registered read port.
module free_list_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // write port and 1-cycle registered read
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/rx_buffer_allocator.sv
// Fixed-slot packet-buffer allocator: circular
// free list with a show-ahead output stage.
module rx_buffer_allocator
  import rx_mem_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH    = 32,
  parameter int PACKET_SIZE_WIDTH = 11,
  parameter int NUM_SLOTS         = DEF_NUM_SLOTS,
  parameter int SLOT_BYTES        = DEF_SLOT_BYTES,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  output logic [AXI_ADDR_WIDTH-1:0]    next_addr_o,
  output logic                         next_addr_valid_o,
  input  logic                         addr_ack_i,
  input  logic [PACKET_SIZE_WIDTH-1:0] packet_length_i,
  input  logic [AXI_ADDR_WIDTH-1:0]    free_addr_i,
  input  logic                         free_valid_i,
  output logic                         free_ready_o,
  output logic [$clog2(NUM_SLOTS):0]   free_slots_o,
  output logic                         init_done_o,
  output logic [2:0]                   err_o
);

  localparam int IW  = $clog2(NUM_SLOTS);
  localparam int SBW = $clog2(SLOT_BYTES);
  localparam int CW  = IW + 1;
  localparam wide_addr_t SPAN =
    MAX_AW'(NUM_SLOTS) << SBW;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        r_state, w_state_nxt;
  logic [IW-1:0] r_init_idx;
  logic [IW-1:0] r_rd_ptr;
  logic [IW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [CW-1:0] r_free_slots;
  logic          r_valid, w_valid_nxt;
  logic [2:0]    r_err, w_err_nxt;

  logic          w_load;
  logic          w_free_acc;
  logic          w_free_ok;
  logic          w_ram_we;
  logic [IW-1:0] w_ram_waddr;
  logic [IW-1:0] w_ram_wdata;
  logic [IW-1:0] w_ram_q;
  logic [IW-1:0] w_idx;
  wide_addr_t    w_free_w, w_base_w, w_off_w;
  logic          w_in_range;
  logic          w_aligned;
  logic          w_len_big;

  assign w_free_w   = MAX_AW'(free_addr_i);
  assign w_base_w   = MAX_AW'(BASE_ADDR);
  assign w_off_w    = w_free_w - w_base_w;
  assign w_in_range = (w_free_w >= w_base_w) &&
                      (w_off_w < SPAN);
  assign w_aligned  = (w_off_w[SBW-1:0] == '0);
  assign w_idx      = IW'(addr_to_idx(
                        w_free_w, w_base_w, SBW));
  assign w_len_big  = MAX_AW'(packet_length_i) >
                      MAX_AW'(SLOT_BYTES);

  free_list_ram #(
    .DEPTH (NUM_SLOTS),
    .WIDTH (IW)
  ) u_ram (
    .i_clk   (clk_i),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_re    (w_load),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_ram_q)
  );

  // next-state, free-list control and error detection
  always_comb begin
    w_state_nxt  = r_state;
    w_load       = 1'b0;
    w_free_acc   = 1'b0;
    w_free_ok    = 1'b0;
    w_ram_we     = 1'b0;
    w_ram_waddr  = r_wr_ptr;
    w_ram_wdata  = w_idx;
    w_valid_nxt  = r_valid;
    w_count_nxt  = r_count;
    w_err_nxt    = r_err;
    free_ready_o = 1'b0;
    init_done_o  = 1'b0;
    unique case (r_state)
      ST_INIT: begin
        w_ram_we    = 1'b1;
        w_ram_waddr = r_init_idx;
        w_ram_wdata = r_init_idx;
        if (r_init_idx == IW'(NUM_SLOTS - 1)) begin
          w_state_nxt = ST_RUN;
          w_count_nxt = CW'(NUM_SLOTS);
        end
      end
      ST_RUN: begin
        init_done_o  = 1'b1;
        free_ready_o = (r_count < CW'(NUM_SLOTS));
        w_load     = (!r_valid || addr_ack_i) &&
                     (r_count != '0);
        w_free_acc = free_valid_i && free_ready_o;
        w_free_ok  = w_free_acc && w_in_range &&
                     w_aligned;
        w_ram_we   = w_free_ok;
        if (w_load)
          w_valid_nxt = 1'b1;
        else if (addr_ack_i)
          w_valid_nxt = 1'b0;
        w_count_nxt = r_count + CW'(w_free_ok) -
                      CW'(w_load);
        if (addr_ack_i && !r_valid)
          w_err_nxt[ERR_ACK_UNDERFLOW] = 1'b1;
        if (w_free_acc && !w_free_ok)
          w_err_nxt[ERR_BAD_FREE] = 1'b1;
        if (addr_ack_i && w_len_big)
          w_err_nxt[ERR_LEN_OVERFLOW] = 1'b1;
      end
      default: ;
    endcase
  end

  // state, pointers, count and registered status
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state      <= ST_INIT;
      r_init_idx   <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_valid      <= 1'b0;
      r_err        <= '0;
      r_free_slots <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT)
        r_init_idx <= r_init_idx + IW'(1);
      if (w_load)
        r_rd_ptr <= r_rd_ptr + IW'(1);
      if (w_free_ok)
        r_wr_ptr <= r_wr_ptr + IW'(1);
      r_count      <= w_count_nxt;
      r_valid      <= w_valid_nxt;
      r_err        <= w_err_nxt;
      r_free_slots <= w_count_nxt + CW'(w_valid_nxt);
    end
  end

  assign next_addr_o = r_valid ?
    AXI_ADDR_WIDTH'(idx_to_addr(MAX_AW'(w_ram_q),
                                w_base_w, SBW)) :
    '0;
  assign next_addr_valid_o = r_valid;
  assign free_slots_o      = r_free_slots;
  assign err_o             = r_err;

endmodule

// File: tb/tb_rx_buffer_allocator.sv
// Bench for rx_buffer_allocator: vector table
// plus an in-order address scoreboard.
module tb_rx_buffer_allocator;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] next_addr;
  logic        valid;
  logic        ack = 1'b0;
  logic [11:0] len = '0;
  logic [31:0] fa = '0;
  logic        fv = 1'b0;
  logic        ready;
  logic [3:0]  slots;
  logic        done;
  logic [2:0]  err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] sb[$];

  typedef struct {
    logic        ack;
    logic [11:0] len;
    logic        fv;
    logic [31:0] fa;
    logic        ev;
    logic [3:0]  es;
    logic [2:0]  ee;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  rx_buffer_allocator #(
    .AXI_ADDR_WIDTH    (32),
    .PACKET_SIZE_WIDTH (12),
    .NUM_SLOTS         (8),
    .SLOT_BYTES        (2048),
    .BASE_ADDR         (BASE)
  ) dut (
    .clk_i             (clk),
    .reset_n_i         (rst_n),
    .next_addr_o       (next_addr),
    .next_addr_valid_o (valid),
    .addr_ack_i        (ack),
    .packet_length_i   (len),
    .free_addr_i       (fa),
    .free_valid_i      (fv),
    .free_ready_o      (ready),
    .free_slots_o      (slots),
    .init_done_o       (done),
    .err_o             (err)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic        a,
    input logic [11:0] l,
    input logic        f,
    input logic [31:0] addr,
    input logic        ev,
    input logic [3:0]  es,
    input logic [2:0]  ee);
    vec_t v;
    v.ack = a; v.len = l; v.fv = f; v.fa = addr;
    v.ev = ev; v.es = es; v.ee = ee;
    return v;
  endfunction

  function automatic logic good(input logic [31:0] a);
    return a >= BASE && a < BASE + 32'h4000 &&
           a[10:0] == 11'd0;
  endfunction

  task automatic apply(input vec_t v);
    ack = v.ack; len = v.len;
    fv = v.fv; fa = v.fa;
    chk("valid", {31'd0, valid}, {31'd0, v.ev});
    chk("slots", {28'd0, slots}, {28'd0, v.es});
    chk("err", {29'd0, err}, {29'd0, v.ee});
    if (v.ev) begin
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else chk("addr", next_addr, sb[0]);
      if (v.ack) void'(sb.pop_front());
    end
    if (v.fv) begin
      chk("ready", {31'd0, ready}, 1);
      if (good(v.fa)) sb.push_back(v.fa);
    end
    @(negedge clk);
  endtask

  task automatic init_check();
    sb.delete();
    for (int k = 0; k < 8; k++)
      sb.push_back(BASE + 32'(k) * 32'h800);
    for (int c = 0; c < 8; c++) begin
      chk("init_busy", {31'd0, done}, 0);
      chk("init_valid", {31'd0, valid}, 0);
      chk("init_ready", {31'd0, ready}, 0);
      @(negedge clk);
    end
    chk("init_done", {31'd0, done}, 1);
    chk("first_lat", {31'd0, valid}, 0);
    @(negedge clk);
    chk("first_valid", {31'd0, valid}, 1);
    chk("first_addr", next_addr, sb[0]);
    chk("first_slots", {28'd0, slots}, 8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1, 12'd100, 0, 0, 1,
                        4'(8 - k), 3'b000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'b000));
    vecs.push_back(mk(0, 0, 1, BASE + 32'h1800,
                      0, 0, 3'b000));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3'b000));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3'b000));
    vecs.push_back(mk(0, 0, 1, BASE + 32'h2000,
                      1, 1, 3'b000));
    vecs.push_back(mk(0, 0, 1, BASE + 32'h2800,
                      1, 2, 3'b000));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 3'b000));
    vecs.push_back(mk(1, 12'd64, 1, BASE,
                      1, 3, 3'b000));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 3'b000));
    vecs.push_back(mk(0, 0, 1, BASE + 32'h4,
                      1, 3, 3'b000));
    vecs.push_back(mk(0, 0, 1, BASE + 32'h4000,
                      1, 3, 3'b010));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 3'b010));
    vecs.push_back(mk(1, 12'd2049, 0, 0,
                      1, 3, 3'b010));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 3'b110));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2, 3'b110));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'b110));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 3'b110));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'b111));
    vecs.push_back(mk(0, 0, 1, BASE + 32'h800,
                      0, 0, 3'b111));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 3'b111));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 3'b111));

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    init_check();

    foreach (vecs[i]) apply(vecs[i]);

    ack = 1'b1; fv = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    ack = 1'b0;
    chk("rst_addr", next_addr, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_ready", {31'd0, ready}, 0);
    chk("rst_slots", {28'd0, slots}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {29'd0, err}, 0);
    rst_n = 1'b1;
    init_check();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
